led_bar_counter: RTL and testbench

LED_BAR_COUNTER -- requirements
Module: led_bar_counter

---
 rtl/led_bar_counter.sv | 202 ++++++++++++++++++++
 tb/tb_led_bar_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_bar_counter.sv
// -----------------------------------------------------------------------------
// led_bar_counter
//
// Purpose:
//   Up/down/clear counter driven by three raw, active-low push buttons, shown
//   on a row of active-low LEDs either as a bar graph or as a single dot.
//   Every button is synchronised, debounced and edge-detected so that one
//   physical press yields exactly one count step. An optional hold-to-repeat
//   feature adds extra steps while btn_up or btn_down stays pressed.
//
// Ports:
//   clk       in   1         sole clock, rising edge
//   rst       in   1         synchronous, active-high reset
//   btn_up    in   1         raw button, active-low, increments count
//   btn_down  in   1         raw button, active-low, decrements count
//   btn_clr   in   1         raw button, active-low, clears count
//   count     out  CNT_W     registered count, 0..NUM_LEDS
//   led       out  NUM_LEDS  LED drive, active-low (0 = lit)
// -----------------------------------------------------------------------------
module led_bar_counter #(
    parameter int NUM_LEDS        = 4,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int WRAP            = 0,
    parameter int DOT_MODE        = 0,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = 13500000,
    parameter int REPEAT_CYCLES   = 2700000,
    localparam int CNT_W          = $clog2(NUM_LEDS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_clr,
    output logic [CNT_W-1:0]    count,
    output logic [NUM_LEDS-1:0] led
);

    // Debounce counter only ever needs to hold 0..DEBOUNCE_CYCLES-1.
    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_LEDS);

    // Button index map: 0 = up, 1 = down, 2 = clear.
    logic [2:0] w_btn_raw;
    logic [2:0] w_stable;
    logic [2:0] w_prev;
    logic [2:0] w_press;
    logic [1:0] w_rep_step;

    assign w_btn_raw = {btn_clr, btn_down, btn_up};

    // -------------------------------------------------------------------------
    // Per-button synchroniser + debouncer + press-edge detector
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic            r_sync1;
            logic            r_sync2;
            logic            r_stable;
            logic            r_prev;
            logic [DB_W-1:0] r_db_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1  <= 1'b1;
                    r_sync2  <= 1'b1;
                    r_stable <= 1'b1;
                    r_prev   <= 1'b1;
                    r_db_cnt <= '0;
                end else begin
                    r_sync1 <= w_btn_raw[gi];
                    r_sync2 <= r_sync1;
                    r_prev  <= r_stable;
                    // Any cycle where the synced input agrees with the stable
                    // value restarts the qualification window, so only an
                    // uninterrupted run of DEBOUNCE_CYCLES differing cycles
                    // can flip the stable value.
                    if (r_sync2 == r_stable) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_stable <= r_sync2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
            end

            assign w_stable[gi] = r_stable;
            assign w_prev[gi]   = r_prev;
        end
    endgenerate

    // Falling edge of the stable (active-low) level = press event.
    assign w_press = ~w_stable & w_prev;

    // -------------------------------------------------------------------------
    // Hold-to-repeat for up (0) and down (1)
    // -------------------------------------------------------------------------
    generate
        if (REPEAT_EN != 0) begin : g_rep
            logic w_both_held;
            assign w_both_held = ~w_stable[0] & ~w_stable[1];

            for (genvar gi = 0; gi < 2; gi++) begin : g_dir
                logic              r_active;
                logic              r_first;
                logic [HOLD_W-1:0] r_hold_cnt;
                logic              w_fire;

                // r_hold_cnt is 0 in the cycle after the press event, so
                // matching N-1 fires exactly N cycles after the event; the
                // first interval is the long hold, later ones the repeat period.
                assign w_fire = r_active & ~w_stable[gi] &
                                (r_hold_cnt == (r_first ? HOLD_W'(HOLD_CYCLES - 1)
                                                        : HOLD_W'(REPEAT_CYCLES - 1)));

                always_ff @(posedge clk) begin
                    if (rst || w_press[2] || w_stable[gi]) begin
                        r_active   <= 1'b0;
                        r_first    <= 1'b1;
                        r_hold_cnt <= '0;
                    end else if (w_press[gi]) begin
                        r_active   <= 1'b1;
                        r_first    <= 1'b1;
                        r_hold_cnt <= '0;
                    end else if (w_fire) begin
                        r_first    <= 1'b0;
                        r_hold_cnt <= '0;
                    end else if (r_active) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end

                // Holding both directions is ambiguous, so it never repeats;
                // the timer still runs so the cadence is kept if one is released.
                assign w_rep_step[gi] = w_fire & ~w_both_held;
            end
        end else begin : g_norep
            assign w_rep_step = 2'b00;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Count register
    // -------------------------------------------------------------------------
    logic             w_ev_up;
    logic             w_ev_dn;
    logic             w_ev_clr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    assign w_ev_up  = w_press[0] | w_rep_step[0];
    assign w_ev_dn  = w_press[1] | w_rep_step[1];
    assign w_ev_clr = w_press[2];

    always_comb begin
        w_count_next = r_count;
        if (w_ev_clr) begin
            w_count_next = '0;
        end else if (w_ev_up && !w_ev_dn) begin
            if (r_count == CNT_MAX) begin
                w_count_next = (WRAP != 0) ? '0 : r_count;
            end else begin
                w_count_next = r_count + 1'b1;
            end
        end else if (w_ev_dn && !w_ev_up) begin
            if (r_count == '0) begin
                w_count_next = (WRAP != 0) ? CNT_MAX : r_count;
            end else begin
                w_count_next = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign count = r_count;

    // -------------------------------------------------------------------------
    // LED decode (active-low), purely from the count register
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            if (DOT_MODE != 0) begin : g_dot
                assign led[gi] = ~(r_count == CNT_W'(gi + 1));
            end else begin : g_bar
                assign led[gi] = ~(r_count > CNT_W'(gi));
            end
        end
    endgenerate

endmodule

// File: tb/tb_led_bar_counter.sv
// -----------------------------------------------------------------------------
// tb_led_bar_counter
//
// Directed bench for led_bar_counter with short debounce/hold timings.
// Three instances share clock and reset:
//   dut_b : WRAP=0, bar display, no repeat
//   dut_w : WRAP=1, dot display, no repeat
//   dut_r : WRAP=0, bar display, hold-to-repeat enabled
// Button vectors are {clr, down, up}, active-low.
// -----------------------------------------------------------------------------
module tb_led_bar_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_b;
    logic [2:0] btn_w;
    logic [2:0] btn_r;
    logic [2:0] count_b;
    logic [2:0] count_w;
    logic [2:0] count_r;
    logic [3:0] led_b;
    logic [3:0] led_w;
    logic [3:0] led_r;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    led_bar_counter #(
        .NUM_LEDS(4), .DEBOUNCE_CYCLES(4), .WRAP(0), .DOT_MODE(0),
        .REPEAT_EN(0), .HOLD_CYCLES(8), .REPEAT_CYCLES(3)
    ) dut_b (
        .clk(clk), .rst(rst),
        .btn_up(btn_b[0]), .btn_down(btn_b[1]), .btn_clr(btn_b[2]),
        .count(count_b), .led(led_b)
    );

    led_bar_counter #(
        .NUM_LEDS(4), .DEBOUNCE_CYCLES(4), .WRAP(1), .DOT_MODE(1),
        .REPEAT_EN(0), .HOLD_CYCLES(8), .REPEAT_CYCLES(3)
    ) dut_w (
        .clk(clk), .rst(rst),
        .btn_up(btn_w[0]), .btn_down(btn_w[1]), .btn_clr(btn_w[2]),
        .count(count_w), .led(led_w)
    );

    led_bar_counter #(
        .NUM_LEDS(4), .DEBOUNCE_CYCLES(4), .WRAP(0), .DOT_MODE(0),
        .REPEAT_EN(1), .HOLD_CYCLES(8), .REPEAT_CYCLES(3)
    ) dut_r (
        .clk(clk), .rst(rst),
        .btn_up(btn_r[0]), .btn_down(btn_r[1]), .btn_clr(btn_r[2]),
        .count(count_r), .led(led_r)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[%0t] check %s: observed %0h expected %0h", $time, tag, obs, exp);
    endtask

    task automatic set_btn(input int d, input logic [2:0] v);
        case (d)
            0:       btn_b = v;
            1:       btn_w = v;
            default: btn_r = v;
        endcase
    endtask

    // Hold the masked buttons low for 'low' cycles, then release and let the
    // release debounce settle.
    task automatic press(input int d, input logic [2:0] mask, input int low);
        set_btn(d, ~mask);
        repeat (low) tick();
        set_btn(d, 3'b111);
        repeat (10) tick();
    endtask

    initial begin
        rst   = 1'b1;
        btn_b = 3'b111;
        btn_w = 3'b111;
        btn_r = 3'b111;
        repeat (3) tick();

        // Reset state
        chk("rst_count_b", count_b, 0);
        chk("rst_led_b",   led_b,   4'hF);
        chk("rst_count_w", count_w, 0);
        chk("rst_led_w",   led_w,   4'hF);
        chk("rst_count_r", count_r, 0);
        rst = 1'b0;
        tick();

        // Press latency: 2 sync + 4 debounce + 1 event = 7 edges after the fall
        btn_b[0] = 1'b0;
        repeat (6) tick();
        chk("lat_before", count_b, 0);
        tick();
        chk("lat_at7", count_b, 1);
        chk("lat_led", led_b, 4'b1110);
        repeat (13) tick();
        chk("held_no_change", count_b, 1);
        btn_b[0] = 1'b1;
        repeat (10) tick();

        // 3-cycle glitches never qualify
        for (int k = 0; k < 3; k++) begin
            btn_b[0] = 1'b0;
            repeat (3) tick();
            btn_b[0] = 1'b1;
            repeat (3) tick();
        end
        repeat (10) tick();
        chk("glitch_ignored", count_b, 1);

        // Up to saturation: 1 -> 4, one extra press stays 4
        for (int k = 0; k < 4; k++) press(0, 3'b001, 10);
        chk("sat_top_count", count_b, 4);
        chk("sat_top_led",   led_b,   4'b0000);

        // Down five times: 3,2,1,0,0
        for (int k = 0; k < 5; k++) begin
            press(0, 3'b010, 10);
            chk("down_step", count_b, (3 - k < 0) ? 0 : 3 - k);
            if (k == 1) chk("down_led_2", led_b, 4'b1100);
        end
        chk("sat_bot_led", led_b, 4'hF);

        // Simultaneous events
        press(0, 3'b001, 10);
        press(0, 3'b001, 10);
        chk("pre_simul", count_b, 2);
        press(0, 3'b011, 10);
        chk("up_down_same", count_b, 2);
        press(0, 3'b101, 10);
        chk("clr_with_up", count_b, 0);

        // Wrap + dot display
        for (int k = 0; k < 3; k++) press(1, 3'b001, 10);
        chk("dot_count3", count_w, 3);
        chk("dot_led3",   led_w,   4'b1011);
        press(1, 3'b001, 10);
        chk("dot_led4", led_w, 4'b0111);
        press(1, 3'b001, 10);
        chk("wrap_up", count_w, 0);
        chk("dot_led0", led_w, 4'hF);
        press(1, 3'b010, 10);
        chk("wrap_down", count_w, 4);

        // Hold-to-repeat: steps at edges 7, 15, 18, 21 after the fall
        btn_r[0] = 1'b0;
        repeat (6) tick();
        chk("rep_e6", count_r, 0);
        tick();
        chk("rep_e7", count_r, 1);
        repeat (7) tick();
        chk("rep_e14", count_r, 1);
        tick();
        chk("rep_e15", count_r, 2);
        repeat (2) tick();
        chk("rep_e17", count_r, 2);
        tick();
        chk("rep_e18", count_r, 3);
        repeat (2) tick();
        chk("rep_e20", count_r, 3);
        tick();
        chk("rep_e21", count_r, 4);
        repeat (9) tick();
        chk("rep_sat", count_r, 4);
        btn_r = 3'b111;
        repeat (10) tick();

        // Short press releases before the first repeat would fire
        press(2, 3'b010, 7);
        chk("short_down", count_r, 3);
        repeat (20) tick();
        chk("release_clears_hold", count_r, 3);

        // Reset mid-debounce and mid-hold
        press(0, 3'b001, 10);
        chk("pre_rst_b", count_b, 1);
        btn_r[1] = 1'b0;
        repeat (7) tick();
        chk("pre_rst_r", count_r, 2);
        btn_b[1] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("midrst_count_b", count_b, 0);
        chk("midrst_led_b",   led_b,   4'hF);
        chk("midrst_count_r", count_r, 0);
        chk("midrst_led_r",   led_r,   4'hF);
        btn_b = 3'b111;
        btn_r = 3'b111;
        tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("no_spurious_b", count_b, 0);
        chk("no_spurious_r", count_r, 0);

        // Button held through reset release: one event after 7 edges
        btn_b[0] = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("held_rst_before", count_b, 0);
        tick();
        chk("held_rst_event", count_b, 1);
        repeat (10) tick();
        chk("held_rst_once", count_b, 1);
        btn_b = 3'b111;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
